// File: rtl/arr_bank.sv
// arr_bank: single-bank word array shared between a kernel datapath port
// (arr*) and a host control port (controlArr*), with a hardware clear
// sequencer and sticky out-of-range detection.
//
// Ports:
//   clk, rst_n                  clock (rising edge), asynchronous active-low reset
//   controlArr                  1 = host owns the bank, kernel strobes ignored
//   controlArrWEnable/REnable   host write / read strobes
//   controlArrAddr/WData        host address / write data
//   controlArrRData/RValid      host read data (held) / one-cycle valid pulse
//   arrWEnable/REnable          kernel write / read strobes
//   arrAddr/WData               kernel address / write data
//   arrRData/RValid             kernel read data (held) / one-cycle valid pulse
//   clearStart                  pulse: start the clear sequence
//   clearBusy                   clear sequence in progress (DEPTH cycles)
//   errOob                      sticky out-of-range access flag
//   errClr                      clears errOob (a simultaneous new error wins)
module arr_bank #(
  parameter int              DATA_W         = 64,
  parameter int              DEPTH          = 16,
  parameter int              ADDR_W         = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter logic [DATA_W-1:0] CLEAR_VALUE  = '0,
  parameter bit              CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              controlArr,
  input  logic              controlArrWEnable,
  input  logic              controlArrREnable,
  input  logic [ADDR_W-1:0] controlArrAddr,
  input  logic [DATA_W-1:0] controlArrWData,
  output logic [DATA_W-1:0] controlArrRData,
  output logic              controlArrRValid,
  input  logic              arrWEnable,
  input  logic              arrREnable,
  input  logic [ADDR_W-1:0] arrAddr,
  input  logic [DATA_W-1:0] arrWData,
  output logic [DATA_W-1:0] arrRData,
  output logic              arrRValid,
  input  logic              clearStart,
  output logic              clearBusy,
  output logic              errOob,
  input  logic              errClr
);

  // One extra bit so DEPTH == 2**ADDR_W is representable in the compare.
  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] ptr_reg;
  logic              start_pend_reg;  // auto-clear request armed by reset
  logic              busy_reg;
  logic              err_oob_reg;

  logic [DATA_W-1:0] mem [DEPTH];

  // Active-port selection: only the owning port's strobes reach the bank.
  logic              sel_we;
  logic              sel_re;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  always_comb begin
    sel_we    = arrWEnable;
    sel_re    = arrREnable;
    sel_addr  = arrAddr;
    sel_wdata = arrWData;
    if (controlArr) begin
      sel_we    = controlArrWEnable;
      sel_re    = controlArrREnable;
      sel_addr  = controlArrAddr;
      sel_wdata = controlArrWData;
    end
  end

  logic idle;
  logic oob;
  logic acc_any;
  logic acc_wr;
  logic acc_rd;
  logic [DATA_W-1:0] rd_word;

  assign idle    = (state_reg == ST_IDLE);
  assign oob     = ({1'b0, sel_addr} >= DEPTH_L);
  assign acc_any = idle && (sel_we || sel_re);
  assign acc_wr  = idle && sel_we && !oob;
  // A simultaneous write takes priority; the read is dropped entirely.
  assign acc_rd  = idle && sel_re && !sel_we;
  assign rd_word = oob ? '0 : mem[sel_addr];

  // Storage is deliberately not reset; the clear sequencer owns the write
  // port while busy so kernel/host writes cannot interleave with it.
  always_ff @(posedge clk) begin
    if (state_reg == ST_CLEAR) begin
      mem[ptr_reg] <= CLEAR_VALUE;
    end else if (acc_wr) begin
      mem[sel_addr] <= sel_wdata;
    end
  end

  // Control FSM, clear pointer and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      ptr_reg        <= '0;
      start_pend_reg <= CLEAR_ON_RESET;
      busy_reg       <= 1'b0;
      err_oob_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          start_pend_reg <= 1'b0;
          if (clearStart || start_pend_reg) begin
            state_reg <= ST_CLEAR;
            ptr_reg   <= '0;
            busy_reg  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          // clearStart is ignored here: the running sequence is not restarted.
          if (ptr_reg == LAST_PTR) begin
            state_reg <= ST_IDLE;
            ptr_reg   <= '0;
            busy_reg  <= 1'b0;
          end else begin
            ptr_reg <= ptr_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase

      if (acc_any && oob) begin
        err_oob_reg <= 1'b1;
      end else if (errClr) begin
        err_oob_reg <= 1'b0;
      end
    end
  end

  // Read return registers, one per port (gi = 0 kernel, gi = 1 host). The
  // owner is latched implicitly: the data lands in the register of whichever
  // port owned the bank at the acceptance edge.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rport
      localparam logic OWNER = (gi == 1);
      logic              rvalid_reg;
      logic [DATA_W-1:0] rdata_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rvalid_reg <= 1'b0;
          rdata_reg  <= '0;
        end else begin
          rvalid_reg <= acc_rd && (controlArr == OWNER);
          if (acc_rd && (controlArr == OWNER)) begin
            rdata_reg <= rd_word;
          end
        end
      end
    end
  endgenerate

  assign arrRValid        = g_rport[0].rvalid_reg;
  assign arrRData         = g_rport[0].rdata_reg;
  assign controlArrRValid = g_rport[1].rvalid_reg;
  assign controlArrRData  = g_rport[1].rdata_reg;
  assign clearBusy        = busy_reg;
  assign errOob           = err_oob_reg;

endmodule

// File: tb/tb_arr_bank.sv
// Scoreboard bench for arr_bank: a DEPTH=16 instance for normal operation,
// ownership and clear handling, plus a DEPTH=12 instance for out-of-range
// behaviour. Expected read data is queued at issue; monitors pop on RValid.
module tb_arr_bank;

  logic clk;
  logic rst_n;

  // DEPTH=16 instance signals
  logic        ca16, hwe16, hre16, kwe16, kre16, cs16, ec16;
  logic [3:0]  ha16, ka16;
  logic [63:0] hwd16, kwd16, hrd16, krd16;
  logic        hrv16, krv16, busy16, err16;

  // DEPTH=12 instance signals
  logic        ca12, hwe12, hre12, kwe12, kre12, cs12, ec12;
  logic [3:0]  ha12, ka12;
  logic [63:0] hwd12, kwd12, hrd12, krd12;
  logic        hrv12, krv12, busy12, err12;

  logic [63:0] qk16[$];
  logic [63:0] qh16[$];
  logic [63:0] qk12[$];
  logic [63:0] qh12[$];

  int n_vec;
  int n_err;

  arr_bank #(.DATA_W(64), .DEPTH(16), .CLEAR_VALUE(64'd0), .CLEAR_ON_RESET(1'b1)) dut16 (
    .clk(clk), .rst_n(rst_n), .controlArr(ca16),
    .controlArrWEnable(hwe16), .controlArrREnable(hre16), .controlArrAddr(ha16),
    .controlArrWData(hwd16), .controlArrRData(hrd16), .controlArrRValid(hrv16),
    .arrWEnable(kwe16), .arrREnable(kre16), .arrAddr(ka16), .arrWData(kwd16),
    .arrRData(krd16), .arrRValid(krv16), .clearStart(cs16), .clearBusy(busy16),
    .errOob(err16), .errClr(ec16)
  );

  arr_bank #(.DATA_W(64), .DEPTH(12), .CLEAR_VALUE(64'd0), .CLEAR_ON_RESET(1'b1)) dut12 (
    .clk(clk), .rst_n(rst_n), .controlArr(ca12),
    .controlArrWEnable(hwe12), .controlArrREnable(hre12), .controlArrAddr(ha12),
    .controlArrWData(hwd12), .controlArrRData(hrd12), .controlArrRValid(hrv12),
    .arrWEnable(kwe12), .arrREnable(kre12), .arrAddr(ka12), .arrWData(kwd12),
    .arrRData(krd12), .arrRValid(krv12), .clearStart(cs12), .clearBusy(busy12),
    .errOob(err12), .errClr(ec12)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    n_vec++;
    n_err++;
    $display("FAIL %s: unexpected rvalid, data %0h, no read outstanding", name, act);
  endtask

  // Monitors: compare on every RValid pulse, sampled on the falling edge.
  always @(negedge clk) begin
    if (krv16) begin
      if (qk16.size() == 0) unexpected("k16_rvalid", krd16);
      else begin
        $display("k16 read return %h", krd16);
        chk("k16_rdata", krd16, qk16.pop_front());
      end
    end
    if (hrv16) begin
      if (qh16.size() == 0) unexpected("h16_rvalid", hrd16);
      else begin
        $display("h16 read return %h", hrd16);
        chk("h16_rdata", hrd16, qh16.pop_front());
      end
    end
    if (krv12) begin
      if (qk12.size() == 0) unexpected("k12_rvalid", krd12);
      else begin
        $display("k12 read return %h", krd12);
        chk("k12_rdata", krd12, qk12.pop_front());
      end
    end
    if (hrv12) begin
      if (qh12.size() == 0) unexpected("h12_rvalid", hrd12);
      else begin
        $display("h12 read return %h", hrd12);
        chk("h12_rdata", hrd12, qh12.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic k16_rd(input logic [3:0] a, input logic [63:0] e);
    kre16 = 1'b1; ka16 = a; qk16.push_back(e);
    tick();
    kre16 = 1'b0;
  endtask

  task automatic k16_wr(input logic [3:0] a, input logic [63:0] d);
    kwe16 = 1'b1; ka16 = a; kwd16 = d;
    tick();
    kwe16 = 1'b0;
  endtask

  task automatic h16_rd(input logic [3:0] a, input logic [63:0] e);
    hre16 = 1'b1; ha16 = a; qh16.push_back(e);
    tick();
    hre16 = 1'b0;
  endtask

  task automatic h16_wr(input logic [3:0] a, input logic [63:0] d);
    hwe16 = 1'b1; ha16 = a; hwd16 = d;
    tick();
    hwe16 = 1'b0;
  endtask

  task automatic k12_rd(input logic [3:0] a, input logic [63:0] e);
    kre12 = 1'b1; ka12 = a; qk12.push_back(e);
    tick();
    kre12 = 1'b0;
  endtask

  task automatic k12_wr(input logic [3:0] a, input logic [63:0] d);
    kwe12 = 1'b1; ka12 = a; kwd12 = d;
    tick();
    kwe12 = 1'b0;
  endtask

  // After reset release both banks clear automatically: 16 and 12 busy cycles.
  task automatic check_startup_clear();
    chk("busy16_before_edge", busy16, 0);
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("busy16_clear", busy16, 1);
      chk("busy12_clear", busy12, (i <= 12) ? 1 : 0);
    end
    tick();
    chk("busy16_done", busy16, 0);
  endtask

  localparam logic [63:0] BEEF = 64'h0000_0000_DEAD_BEEF;
  localparam logic [63:0] HVAL = 64'h1234_5678_9ABC_DEF0;

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b0;
    ca16 = 0; hwe16 = 0; hre16 = 0; kwe16 = 0; kre16 = 0; cs16 = 0; ec16 = 0;
    ha16 = '0; ka16 = '0; hwd16 = '0; kwd16 = '0;
    ca12 = 0; hwe12 = 0; hre12 = 0; kwe12 = 0; kre12 = 0; cs12 = 0; ec12 = 0;
    ha12 = '0; ka12 = '0; hwd12 = '0; kwd12 = '0;

    // Reset state
    repeat (3) tick();
    chk("rst_krv16", krv16, 0);
    chk("rst_hrv16", hrv16, 0);
    chk("rst_krd16", krd16, 0);
    chk("rst_hrd16", hrd16, 0);
    chk("rst_busy16", busy16, 0);
    chk("rst_err16", err16, 0);
    chk("rst_err12", err12, 0);
    rst_n = 1'b1;
    check_startup_clear();

    // Whole bank cleared: back-to-back kernel reads, one pulse each
    for (int a = 0; a < 16; a++) k16_rd(4'(a), 64'd0);

    // Write then read next cycle
    k16_wr(4'd3, BEEF);
    k16_rd(4'd3, BEEF);

    // Ownership: host owns, kernel write and read are dropped
    ca16 = 1'b1;
    k16_wr(4'd5, 64'd7);
    h16_rd(4'd5, 64'd0);
    kre16 = 1'b1; ka16 = 4'd5;
    tick();
    kre16 = 1'b0;
    ca16 = 1'b0;
    k16_rd(4'd5, 64'd0);

    // Host read, then ownership flips to kernel: data still on host port
    ca16 = 1'b1;
    h16_wr(4'd6, HVAL);
    h16_rd(4'd6, HVAL);
    ca16 = 1'b0;
    k16_rd(4'd3, BEEF);
    tick();

    // Clear: clearStart retrigger ignored, writes/reads dropped while busy
    cs16 = 1'b1;
    tick();
    cs16 = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      chk("busy16_manual_clear", busy16, 1);
      if (i == 5) begin
        cs16 = 1'b1; kwe16 = 1'b1; ka16 = 4'd7; kwd16 = 64'h55;
      end
      if (i == 8) begin
        kre16 = 1'b1; ka16 = 4'd3;
      end
      tick();
      cs16 = 1'b0; kwe16 = 1'b0; kre16 = 1'b0;
    end
    chk("busy16_manual_done", busy16, 0);
    k16_rd(4'd7, 64'd0);
    k16_rd(4'd3, 64'd0);
    k16_rd(4'd6, 64'd0);

    // Out-of-range on DEPTH=12
    k12_wr(4'd11, 64'h99);
    chk("err12_clean", err12, 0);
    k12_wr(4'd13, 64'hAA);
    chk("err12_oob_write", err12, 1);
    k12_rd(4'd13, 64'd0);
    ec12 = 1'b1;
    tick();
    ec12 = 1'b0;
    chk("err12_cleared", err12, 0);
    ec12 = 1'b1;
    k12_rd(4'd14, 64'd0);
    ec12 = 1'b0;
    chk("err12_set_wins", err12, 1);
    k12_rd(4'd11, 64'h99);
    k12_rd(4'd1, 64'd0);
    tick();

    // Reset in the middle of a clear
    k16_wr(4'd3, BEEF);
    k16_rd(4'd3, BEEF);
    cs16 = 1'b1;
    tick();
    cs16 = 1'b0;
    repeat (5) tick();
    chk("busy16_mid_clear", busy16, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy16", busy16, 0);
    chk("arst_krd16", krd16, 0);
    chk("arst_hrd16", hrd16, 0);
    chk("arst_krv16", krv16, 0);
    chk("arst_err12", err12, 0);
    chk("arst_krd12", krd12, 0);
    tick();
    tick();
    rst_n = 1'b1;
    check_startup_clear();
    k16_rd(4'd3, 64'd0);
    k16_rd(4'd15, 64'd0);
    k12_rd(4'd11, 64'd0);

    repeat (3) tick();
    chk("qk16_drained", qk16.size(), 0);
    chk("qh16_drained", qh16.size(), 0);
    chk("qk12_drained", qk12.size(), 0);
    chk("qh12_drained", qh12.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
